// File: rtl/lfsr_checker_if.sv
// Serial PRBS checker link: received bit stream in, lock/error status out.
// The status side is registered in the checker; the bit side has no backpressure.
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);
  logic             bit_in;
  logic             bit_valid;
  logic             err_clr;
  logic             locked;
  logic             bit_error;
  logic [CNT_W-1:0] error_count;

  modport master (
    output bit_in, bit_valid, err_clr,
    input  locked, bit_error, error_count
  );

  modport slave (
    input  bit_in, bit_valid, err_clr,
    output locked, bit_error, error_count
  );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: fill, hunt for lock, then flywheel and count errors.
// Status is visible one cycle after the deciding bit; no backpressure, bit_valid low holds all state.
module lfsr_checker #(
  parameter int              WIDTH      = 5,
  parameter logic [WIDTH-1:0] TAPS      = 5'b10010,
  parameter int              LOCK_COUNT = 8,
  parameter int              ERR_LIMIT  = 4,
  parameter int              CNT_W      = 16
) (
  input logic           clk,
  input logic           rst,
  lfsr_checker_if.slave chk
);

  typedef enum logic [1:0] {FILL, HUNT, LOCKED} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] hist, hist_n;
  logic [5:0]       fill_cnt, fill_n;
  logic [7:0]       match_cnt, match_n;
  logic [7:0]       miss_cnt, miss_n;
  logic [CNT_W-1:0] err_cnt, err_cnt_n;
  logic             bit_err_q, bit_err_n;
  logic             pred;

  assign pred = ^(hist & TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      hist      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_cnt   <= '0;
      bit_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      hist      <= hist_n;
      fill_cnt  <= fill_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      err_cnt   <= err_cnt_n;
      bit_err_q <= bit_err_n;
    end
  end

  always_comb begin
    state_n   = state;
    hist_n    = hist;
    fill_n    = fill_cnt;
    match_n   = match_cnt;
    miss_n    = miss_cnt;
    err_cnt_n = err_cnt;
    bit_err_n = 1'b0;

    if (chk.bit_valid) begin
      unique case (state)
        FILL: begin
          hist_n = {hist[WIDTH-2:0], chk.bit_in};
          fill_n = fill_cnt + 6'd1;
          if (fill_cnt == 6'(WIDTH - 1)) begin
            state_n = HUNT;
            fill_n  = '0;
          end
        end

        HUNT: begin
          hist_n = {hist[WIDTH-2:0], chk.bit_in};
          // An all-zero history predicts zero forever, so it must never count toward lock.
          if ((chk.bit_in == pred) && (hist != '0)) begin
            match_n = match_cnt + 8'd1;
            if (match_n == 8'(LOCK_COUNT)) begin
              state_n = LOCKED;
              match_n = '0;
              miss_n  = '0;
            end
          end else begin
            match_n = '0;
          end
        end

        LOCKED: begin
          // Flywheel on the prediction so a flipped line bit cannot corrupt the history.
          hist_n = {hist[WIDTH-2:0], pred};
          if (chk.bit_in != pred) begin
            bit_err_n = 1'b1;
            if (err_cnt != '1) err_cnt_n = err_cnt + CNT_W'(1);
            miss_n  = miss_cnt + 8'd1;
            match_n = '0;
            if (miss_n == 8'(ERR_LIMIT)) state_n = HUNT;
          end else begin
            match_n = match_cnt + 8'd1;
            if (match_n == 8'(LOCK_COUNT)) begin
              match_n = '0;
              miss_n  = '0;
            end
          end
        end

        default: state_n = FILL;
      endcase
    end

    if (chk.err_clr) err_cnt_n = bit_err_n ? CNT_W'(1) : '0;
  end

  assign chk.locked      = (state == LOCKED);
  assign chk.bit_error   = bit_err_q;
  assign chk.error_count = err_cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: vector table for lock/error/clear sequences,
// plus hand-written idle-line, random-gap and asynchronous-reset sequences.
module tb_lfsr_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lfsr_checker_if #(.CNT_W(16)) ifc ();
  lfsr_checker_if #(.CNT_W(2))  ifs ();

  lfsr_checker dut (
    .clk (clk),
    .rst (rst),
    .chk (ifc.slave)
  );

  // Narrow-counter copy driven identically, to exercise error_count saturation.
  lfsr_checker #(.CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .chk (ifs.slave)
  );

  typedef struct {
    logic b;
    logic v;
    logic c;
    logic el;
    logic ee;
    int   ec;
  } vec_t;

  vec_t       tbl[$];
  logic [4:0] gen;
  int         vectors = 0;
  int         miscompares = 0;

  // Reference 5-bit generator: emit gen[4], then shift in gen[4]^gen[1].
  task automatic add(input logic inv, input logic v, input logic c,
                     input logic el, input logic ee, input int ec);
    vec_t t;
    t.v  = v;
    t.c  = c;
    t.el = el;
    t.ee = ee;
    t.ec = ec;
    if (v) begin
      t.b = gen[4] ^ inv;
      gen = {gen[3:0], gen[4] ^ gen[1]};
    end else begin
      t.b = ~gen[4];
    end
    tbl.push_back(t);
  endtask

  task automatic add_n(input int n, input logic inv, input logic v, input logic c,
                       input logic el, input logic ee, input int ec);
    for (int k = 0; k < n; k++) add(inv, v, c, el, ee, ec);
  endtask

  task automatic drive(input logic b, input logic v, input logic c);
    ifc.bit_in = b;  ifc.bit_valid = v;  ifc.err_clr = c;
    ifs.bit_in = b;  ifs.bit_valid = v;  ifs.err_clr = c;
  endtask

  task automatic step(input logic b, input logic v, input logic c);
    drive(b, v, c);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic el, input logic ee, input int ec);
    logic [1:0] sat;
    sat = (ec > 3) ? 2'd3 : 2'(ec);
    vectors++;
    if (ifc.locked !== el || ifc.bit_error !== ee || ifc.error_count !== 16'(ec) ||
        ifs.error_count !== sat) begin
      miscompares++;
      $display("FAIL %s: got locked=%0b bit_error=%0b error_count=%0d sat_count=%0d, required %0b %0b %0d %0d",
               name, ifc.locked, ifc.bit_error, ifc.error_count, ifs.error_count,
               el, ee, ec, sat);
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset", 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int nvalid;
    logic v;
    logic b;

    // Vector table.
    gen = 5'b00001;
    add_n(12, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0);
    add_n(100, 0, 1, 0, 1, 0, 0);
    add(1, 1, 0, 1, 1, 1);
    add_n(40, 0, 1, 0, 1, 0, 1);
    add(1, 1, 0, 1, 1, 2);
    add_n(2, 0, 0, 0, 1, 0, 2);
    add_n(10, 0, 1, 0, 1, 0, 2);
    add(1, 1, 1, 1, 1, 1);
    add_n(10, 0, 1, 0, 1, 0, 1);
    add(0, 1, 1, 1, 0, 0);
    add_n(9, 0, 1, 0, 1, 0, 0);
    add(1, 1, 0, 1, 1, 1);
    add(0, 1, 0, 1, 0, 1);
    add(1, 1, 0, 1, 1, 2);
    add(0, 1, 0, 1, 0, 2);
    add(1, 1, 0, 1, 1, 3);
    add(0, 1, 0, 1, 0, 3);
    add(1, 1, 0, 0, 1, 4);
    add_n(7, 0, 1, 0, 0, 0, 4);
    add(0, 1, 0, 1, 0, 4);
    add_n(5, 0, 1, 0, 1, 0, 4);

    drive(1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 check("reset_initial", 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].b, tbl[i].v, tbl[i].c);
      check($sformatf("vec%0d", i), tbl[i].el, tbl[i].ee, tbl[i].ec);
    end

    // Idle-low line must never lock.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check($sformatf("idle%0d", i), 1'b0, 1'b0, 0);
    end

    // Clean stream with random gaps: lock exactly on the 13th valid bit.
    do_reset();
    gen = 5'b00001;
    nvalid = 0;
    for (int cyc = 0; cyc < 300 && nvalid < 13; cyc++) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        b = gen[4];
        gen = {gen[3:0], gen[4] ^ gen[1]};
        nvalid++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      step(b, v, 1'b0);
      check($sformatf("gap%0d", cyc), (nvalid >= 13), 1'b0, 0);
    end
    vectors++;
    if (nvalid != 13) begin
      miscompares++;
      $display("FAIL gap_budget: got %0d valid bits, required 13", nvalid);
    end

    // Three errors spaced two apart stay locked, then reset asynchronously.
    for (int e = 1; e <= 3; e++) begin
      step(~gen[4], 1'b1, 1'b0);
      gen = {gen[3:0], gen[4] ^ gen[1]};
      check($sformatf("pre_rst_err%0d", e), 1'b1, 1'b1, e);
      if (e < 3) begin
        step(gen[4], 1'b1, 1'b0);
        gen = {gen[3:0], gen[4] ^ gen[1]};
        check($sformatf("pre_rst_ok%0d", e), 1'b1, 1'b0, e);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async", 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
    gen = 5'b00001;
    for (int i = 1; i <= 13; i++) begin
      step(gen[4], 1'b1, 1'b0);
      gen = {gen[3:0], gen[4] ^ gen[1]};
      check($sformatf("relock%0d", i), (i == 13), 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
